// File: rtl/fp16_operand_align_if.sv
// Valid/ready bus for the FP16 pre-adder alignment stage.
// Master drives operands and out_ready; slave returns the aligned pair.
interface fp16_operand_align_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int SIG_W = MAN_W + 4
);
    logic [EXP_W+MAN_W:0] in_a;
    logic [EXP_W+MAN_W:0] in_b;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign_big;
    logic                 out_sign_small;
    logic [EXP_W-1:0]     out_exp;
    logic [SIG_W-1:0]     out_mant_big;
    logic [SIG_W-1:0]     out_mant_small;
    logic                 out_swapped;
    logic                 out_special;

    modport master (
        output in_a, in_b, in_valid, out_ready,
        input  in_ready, out_valid, out_sign_big, out_sign_small,
        input  out_exp, out_mant_big, out_mant_small,
        input  out_swapped, out_special
    );

    modport slave (
        input  in_a, in_b, in_valid, out_ready,
        output in_ready, out_valid, out_sign_big, out_sign_small,
        output out_exp, out_mant_big, out_mant_small,
        output out_swapped, out_special
    );
endinterface

// File: rtl/fp16_operand_align.sv
// FP16 pre-adder alignment: unpack, magnitude compare, then shift the
// smaller significand right with guard/round/sticky. Two-stage pipeline.
module fp16_operand_align #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int SIG_W = MAN_W + 4
) (
    input logic                clk,
    input logic                rst,
    fp16_operand_align_if.slave bus
);
    localparam int MAG_W = EXP_W + MAN_W;

    logic             s1_en;
    logic             s2_en;

    logic             s1_valid;
    logic             s1_sign_big;
    logic             s1_sign_small;
    logic [EXP_W-1:0] s1_exp;
    logic [EXP_W-1:0] s1_diff;
    logic [SIG_W-1:0] s1_mb;
    logic [SIG_W-1:0] s1_ms;
    logic             s1_swapped;
    logic             s1_special;

    logic             s2_valid;
    logic             s2_sign_big;
    logic             s2_sign_small;
    logic [EXP_W-1:0] s2_exp;
    logic [SIG_W-1:0] s2_mb;
    logic [SIG_W-1:0] s2_ms;
    logic             s2_swapped;
    logic             s2_special;

    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;
    logic             swap;
    logic             special;

    logic [SIG_W-1:0] sh_mask;
    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] aligned;

    assign s2_en        = !s2_valid || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = s1_en;

    // Subnormals flush to zero: exponent 0 already, significand forced 0.
    always_comb begin
        exp_a   = bus.in_a[MAG_W-1 -: EXP_W];
        exp_b   = bus.in_b[MAG_W-1 -: EXP_W];
        mag_a   = '0;
        mag_b   = '0;
        sig_a   = '0;
        sig_b   = '0;
        if (exp_a != '0) begin
            mag_a = bus.in_a[MAG_W-1:0];
            sig_a = {1'b1, bus.in_a[MAN_W-1:0], 3'b000};
        end
        if (exp_b != '0) begin
            mag_b = bus.in_b[MAG_W-1:0];
            sig_b = {1'b1, bus.in_b[MAN_W-1:0], 3'b000};
        end
        swap    = mag_b > mag_a;
        special = (&exp_a) || (&exp_b);
    end

    // Shift counts at or past SIG_W leave only the sticky bit.
    always_comb begin
        sh_mask = ~({SIG_W{1'b1}} << s1_diff);
        shifted = s1_ms >> s1_diff;
        aligned = {shifted[SIG_W-1:1],
                   shifted[0] | (|(s1_ms & sh_mask))};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sign_big   <= 1'b0;
            s1_sign_small <= 1'b0;
            s1_exp        <= '0;
            s1_diff       <= '0;
            s1_mb         <= '0;
            s1_ms         <= '0;
            s1_swapped    <= 1'b0;
            s1_special    <= 1'b0;
            s2_valid      <= 1'b0;
            s2_sign_big   <= 1'b0;
            s2_sign_small <= 1'b0;
            s2_exp        <= '0;
            s2_mb         <= '0;
            s2_ms         <= '0;
            s2_swapped    <= 1'b0;
            s2_special    <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_swapped <= swap;
                    s1_special <= special;
                    if (swap) begin
                        s1_sign_big   <= bus.in_b[MAG_W];
                        s1_sign_small <= bus.in_a[MAG_W];
                        s1_exp        <= exp_b;
                        s1_diff       <= exp_b - exp_a;
                        s1_mb         <= sig_b;
                        s1_ms         <= sig_a;
                    end else begin
                        s1_sign_big   <= bus.in_a[MAG_W];
                        s1_sign_small <= bus.in_b[MAG_W];
                        s1_exp        <= exp_a;
                        s1_diff       <= exp_a - exp_b;
                        s1_mb         <= sig_a;
                        s1_ms         <= sig_b;
                    end
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sign_big   <= s1_sign_big;
                    s2_sign_small <= s1_sign_small;
                    s2_exp        <= s1_exp;
                    s2_mb         <= s1_mb;
                    s2_ms         <= aligned;
                    s2_swapped    <= s1_swapped;
                    s2_special    <= s1_special;
                end
            end
        end
    end

    assign bus.out_valid      = s2_valid;
    assign bus.out_sign_big   = s2_sign_big;
    assign bus.out_sign_small = s2_sign_small;
    assign bus.out_exp        = s2_exp;
    assign bus.out_mant_big   = s2_mb;
    assign bus.out_mant_small = s2_ms;
    assign bus.out_swapped    = s2_swapped;
    assign bus.out_special    = s2_special;
endmodule

// File: tb/tb_fp16_operand_align.sv
// Bench for fp16_operand_align: vector table, backpressure, reset and
// random streams, all checked through an in-order scoreboard.
module tb_fp16_operand_align;
    typedef struct packed {
        logic        sb;
        logic        ss;
        logic [4:0]  ex;
        logic [13:0] mb;
        logic [13:0] ms;
        logic        sw;
        logic        sp;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        res_t        e;
    } vec_t;

    typedef struct {
        res_t e;
        int   t;
    } sbe_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp16_operand_align_if bus ();

    fp16_operand_align dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    sbe_t q[$];
    vec_t tbl[$];
    res_t cur_exp;
    res_t held;
    bit   stall;
    bit   chk_lat;
    int   n_cmp;
    int   n_fail;
    int   cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic res_t dut_res();
        res_t r;
        r.sb = bus.out_sign_big;
        r.ss = bus.out_sign_small;
        r.ex = bus.out_exp;
        r.mb = bus.out_mant_big;
        r.ms = bus.out_mant_small;
        r.sw = bus.out_swapped;
        r.sp = bus.out_special;
        return r;
    endfunction

    function automatic res_t model(input logic [15:0] a,
                                   input logic [15:0] b);
        res_t        r;
        logic [4:0]  ea;
        logic [4:0]  eb;
        logic [14:0] fa;
        logic [14:0] fb;
        logic [13:0] sa;
        logic [13:0] sbg;
        logic [13:0] s;
        int          d;
        bit          st;
        ea  = a[14:10];
        eb  = b[14:10];
        fa  = (ea == 0) ? 15'd0 : a[14:0];
        fb  = (eb == 0) ? 15'd0 : b[14:0];
        sa  = (ea == 0) ? 14'd0 : {1'b1, a[9:0], 3'b000};
        sbg = (eb == 0) ? 14'd0 : {1'b1, b[9:0], 3'b000};
        r.sw = fb > fa;
        if (r.sw) begin
            r.sb = b[15]; r.ss = a[15]; r.ex = eb;
            r.mb = sbg; s = sa; d = int'(eb) - int'(ea);
        end else begin
            r.sb = a[15]; r.ss = b[15]; r.ex = ea;
            r.mb = sa; s = sbg; d = int'(ea) - int'(eb);
        end
        st = 1'b0;
        for (int i = 0; i < d; i++) begin
            st = st | s[0];
            s  = s >> 1;
        end
        s[0] = s[0] | st;
        r.ms = s;
        r.sp = (ea == 5'd31) || (eb == 5'd31);
        return r;
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic sb, input logic ss,
                                input logic [4:0] ex, input logic [13:0] mb,
                                input logic [13:0] ms, input logic sw,
                                input logic sp);
        vec_t v;
        v.a = a; v.b = b;
        v.e.sb = sb; v.e.ss = ss; v.e.ex = ex; v.e.mb = mb;
        v.e.ms = ms; v.e.sw = sw; v.e.sp = sp;
        return v;
    endfunction

    // Scoreboard: push on accept, pop and compare on retire.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall = 1'b0;
        end else begin
            chk("in_ready", 64'(bus.in_ready),
                64'((q.size() < 2) || bus.out_ready));
            chk("spurious", 64'(bus.out_valid && q.size() == 0), 64'd0);
            if (stall) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", 64'(dut_res()), 64'(held));
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                sbe_t e;
                e = q.pop_front();
                chk("beat", 64'(dut_res()), 64'(e.e));
                if (chk_lat) chk("latency", 64'(cyc - e.t), 64'd2);
            end
            if (bus.in_valid && bus.in_ready) begin
                sbe_t n;
                n.e = cur_exp;
                n.t = cyc;
                q.push_back(n);
            end
            stall = bus.out_valid && !bus.out_ready;
            held  = dut_res();
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input res_t e);
        bit acc;
        bus.in_a     = a;
        bus.in_b     = b;
        cur_exp      = e;
        bus.in_valid = 1'b1;
        acc          = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] bpa[4];
        logic [15:0] bpb[4];
        int          k;
        bit          acc;

        n_cmp = 0; n_fail = 0; cyc = 0;
        chk_lat = 1'b0; stall = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.out_ready = 1'b1;
        cur_exp = '0;

        tbl.push_back(mk(16'h3C00, 16'h3800, 0, 0, 15, 14'h2000, 14'h1000, 0, 0));
        tbl.push_back(mk(16'h3800, 16'h3C00, 0, 0, 15, 14'h2000, 14'h1000, 1, 0));
        tbl.push_back(mk(16'h4500, 16'h4500, 0, 0, 17, 14'h2800, 14'h2800, 0, 0));
        tbl.push_back(mk(16'h4C00, 16'h3C01, 0, 0, 19, 14'h2000, 14'h0201, 0, 0));
        tbl.push_back(mk(16'h7800, 16'h3C01, 0, 0, 30, 14'h2000, 14'h0001, 0, 0));
        tbl.push_back(mk(16'h0000, 16'h8000, 0, 1, 0, 14'h0000, 14'h0000, 0, 0));
        tbl.push_back(mk(16'h7C00, 16'h3C00, 0, 0, 31, 14'h2000, 14'h0001, 0, 1));
        tbl.push_back(mk(16'h3C00, 16'h0000, 0, 0, 15, 14'h2000, 14'h0000, 0, 0));
        tbl.push_back(mk(16'h0001, 16'hC000, 1, 0, 16, 14'h2000, 14'h0000, 1, 0));
        tbl.push_back(mk(16'h3C00, 16'h3FFF, 0, 0, 15, 14'h3FF8, 14'h2000, 1, 0));
        tbl.push_back(mk(16'h7E00, 16'hFC00, 0, 1, 31, 14'h3000, 14'h2000, 0, 1));
        tbl.push_back(mk(16'hC400, 16'h3C03, 1, 0, 17, 14'h2000, 14'h0806, 0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(dut_res()), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        chk_lat = 1'b1;
        foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].e);
        drain();
        chk_lat = 1'b0;

        // Four beats with the sink stalled for cycles 2..5.
        bpa[0] = 16'h4000; bpb[0] = 16'h3C00;
        bpa[1] = 16'h3A00; bpb[1] = 16'h4900;
        bpa[2] = 16'h5000; bpb[2] = 16'h8C07;
        bpa[3] = 16'hB800; bpb[3] = 16'hB800;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            bus.out_ready = !(c >= 2 && c <= 5);
            if (k < 4) begin
                bus.in_a     = bpa[k];
                bus.in_b     = bpb[k];
                cur_exp      = model(bpa[k], bpb[k]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 2 && c <= 5) chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            if (c >= 2 && c <= 9) chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            if (bus.in_valid && bus.in_ready) k++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 64'(k), 64'd4);
        bus.out_ready = 1'b1;
        drain();

        // Reset with two beats buffered; nothing may come out afterwards.
        bus.out_ready = 1'b0;
        send(16'h3C00, 16'h3800, model(16'h3C00, 16'h3800));
        send(16'h4400, 16'h4200, model(16'h4400, 16'h4200));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_flight_valid", 64'(bus.out_valid), 64'd0);
        repeat (8) @(posedge clk);
        #1;

        // Random traffic with random sink stalls.
        acc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !bus.in_valid) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if ($urandom_range(0, 3) == 0)
                    rb[14:10] = ra[14:10] + 5'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) ra[14:10] = 5'd0;
                bus.in_a     = ra;
                bus.in_b     = rb;
                cur_exp      = model(ra, rb);
                bus.in_valid = ($urandom_range(0, 4) != 0);
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
